// File: rtl/uart_writer_pkg.sv
// uart_writer_pkg: sync byte, loader states and default frame/timeout constants shared with the VGA side
package uart_writer_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PIXEL_WIDTH_DEF = 12;
  localparam int ADDR_WIDTH_DEF = 19;
  localparam int TIMEOUT_CYCLES_DEF = 200000;
  localparam int TIMEOUT_WIDTH_DEF = 18;
  typedef enum logic [1:0] {IDLE, HI, LO} loader_state_t;
endpackage

// File: rtl/byte_timeout_timer.sv
// byte_timeout_timer: counts idle cycles between bytes; a clear on the terminal count wins over expiry
module byte_timeout_timer import uart_writer_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam logic [TIMEOUT_WIDTH-1:0] TERM = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_WIDTH-1:0] cnt;
  assign expired = enable && !clear && cnt == TERM;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (!enable || clear || expired) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: turns a sync-prefixed UART byte stream into sequential frame-buffer pixel writes
module uart_frame_loader import uart_writer_pkg::*; #(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_data_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_error
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(H_RES * V_RES - 1);
  loader_state_t state;
  logic [ADDR_WIDTH-1:0] pix_idx;
  logic [7:0] hi_byte;
  logic expired;
  byte_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_WIDTH(TIMEOUT_WIDTH)) u_timer (
    .clk(clk), .reset(reset), .enable(state != IDLE), .clear(rx_data_ready), .expired(expired)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pix_idx <= '0;
      hi_byte <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      frame_done <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE) begin
        if (rx_data_ready && rx_data == SYNC_BYTE) begin
          state <= HI;
          busy <= 1'b1;
          pix_idx <= '0;
        end
      end else if (rx_data_ready) begin
        if (state == HI) begin
          hi_byte <= rx_data;
          state <= LO;
        end else begin
          wr_en <= 1'b1;
          wr_data <= PIXEL_WIDTH'({hi_byte, rx_data});
          wr_addr <= pix_idx;
          frame_done <= pix_idx == LAST;
          pix_idx <= (pix_idx == LAST) ? '0 : pix_idx + 1'b1;
          state <= (pix_idx == LAST) ? IDLE : HI;
          busy <= pix_idx != LAST;
        end
      end else if (expired) begin
        frame_error <= 1'b1;
        state <= IDLE;
        busy <= 1'b0;
        pix_idx <= '0;
      end
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: directed checks of sync, pixel writes, timeout, reset abort and terminal-count race
module tb_uart_frame_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_data_ready = 1'b0;
  logic wr_en, busy, frame_done, frame_error;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  int tests = 0;
  int fails = 0;
  int writes = 0;
  int errors = 0;

  uart_frame_loader #(.H_RES(4), .V_RES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) writes++;
    if (frame_error) errors++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] h, input logic [7:0] l, input int addr,
                            input logic [11:0] data, input bit done);
    strobe(h);
    gap(9);
    strobe(l);
    chk("wr_en", wr_en, 1);
    chk("wr_addr", wr_addr, addr);
    chk("wr_data", wr_data, data);
    chk("frame_done", frame_done, done);
    chk("no_error", frame_error, 0);
    if (!done) chk("busy_mid", busy, 1);
    gap(1);
    chk("wr_en_pulse", wr_en, 0);
    chk("busy_after", busy, !done);
    chk("done_pulse", frame_done, 0);
    gap(8);
  endtask

  task automatic pixels(input int first, input int last_i, input logic [7:0] seed);
    for (int i = first; i <= last_i; i++) begin
      logic [7:0] h, l;
      h = seed + 8'(i);
      l = 8'h5A ^ (seed + 8'(3 * i));
      send_pixel(h, l, i, {h[3:0], l}, i == 7);
    end
  endtask

  task automatic frame(input logic [7:0] seed);
    strobe(8'hA5);
    chk("sync_busy", busy, 1);
    gap(9);
    pixels(0, 7, seed);
  endtask

  initial begin
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_error, 0);
    reset = 1'b1;
    gap(3);

    // 1: basic frame
    strobe(8'hA5);
    chk("t1_busy", busy, 1);
    gap(9);
    send_pixel(8'h0F, 8'hFF, 0, 12'hFFF, 0);
    send_pixel(8'h01, 8'h23, 1, 12'h123, 0);
    pixels(2, 7, 8'h30);
    chk("t1_writes", writes, 8);

    // 2: leading junk ignored
    strobe(8'h00);
    chk("t2_busy0", busy, 0);
    chk("t2_wr0", wr_en, 0);
    gap(9);
    strobe(8'h11);
    chk("t2_busy1", busy, 0);
    chk("t2_wr1", wr_en, 0);
    gap(9);
    chk("t2_writes", writes, 8);
    frame(8'h44);
    chk("t2_writes_end", writes, 16);

    // 3: timeout after 3 pixels
    strobe(8'hA5);
    gap(9);
    pixels(0, 2, 8'h50);
    gap(90);
    chk("t3_err_early", frame_error, 0);
    chk("t3_busy_early", busy, 1);
    gap(1);
    chk("t3_err", frame_error, 1);
    chk("t3_busy", busy, 0);
    chk("t3_no_write", wr_en, 0);
    gap(1);
    chk("t3_err_pulse", frame_error, 0);
    chk("t3_err_count", errors, 1);
    frame(8'h61);
    chk("t3_writes", writes, 27);

    // 4: sync byte as pixel data
    strobe(8'hA5);
    gap(9);
    pixels(0, 1, 8'h70);
    send_pixel(8'hA5, 8'hA5, 2, 12'h5A5, 0);
    pixels(3, 7, 8'h70);
    chk("t4_writes", writes, 35);

    // 5: reset during LO
    strobe(8'hA5);
    gap(9);
    pixels(0, 1, 8'h80);
    strobe(8'h9C);
    gap(3);
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", wr_addr, 0);
    chk("t5_rst_data", wr_data, 0);
    #3;
    reset = 1'b1;
    gap(2);
    strobe(8'h3C);
    chk("t5_orphan_wr", wr_en, 0);
    chk("t5_orphan_busy", busy, 0);
    gap(9);
    chk("t5_writes", writes, 37);
    frame(8'h91);
    chk("t5_writes_end", writes, 45);

    // 6: strobe exactly at terminal count
    strobe(8'hA5);
    gap(9);
    pixels(0, 3, 8'hC2);
    gap(90);
    strobe(8'hD7);
    chk("t6_no_err", frame_error, 0);
    chk("t6_busy", busy, 1);
    gap(9);
    strobe(8'h4B);
    chk("t6_wr", wr_en, 1);
    chk("t6_addr", wr_addr, 4);
    chk("t6_data", wr_data, 12'h74B);
    gap(9);
    pixels(5, 7, 8'hC2);
    chk("t6_err_count", errors, 1);
    chk("t6_writes", writes, 53);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Downstream consumer of the UART receiver's byte stream. Waits for a sync byte, then assembles byte pairs into pixels and issues sequential write commands into the VGA frame buffer, one full frame per sync. Detects truncated transfers with an inter-byte timeout. Sits between the UART receiver and the frame-buffer write port, ahead of the convolution/VGA read side.

Parameters:
H_RES, 640, pixels per line
V_RES, 480, lines per frame
PIXEL_WIDTH, 12, frame-buffer word width (RGB444); must be ≤16
ADDR_WIDTH, 19, frame-buffer address width; must satisfy 2**ADDR_WIDTH ≥ H_RES*V_RES
TIMEOUT_CYCLES, 200000, max clk cycles between bytes inside a frame (~4 byte times at 9600 baud, 50 MHz)
TIMEOUT_WIDTH, 18, width of the timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received byte from the UART receiver
rx_data_ready  input  1  single-cycle strobe; rx_data valid this cycle
wr_en  output  1  frame-buffer write strobe, one cycle per pixel
wr_addr  output  ADDR_WIDTH  linear pixel address, row-major, 0..H_RES*V_RES-1
wr_data  output  PIXEL_WIDTH  pixel value
busy  output  1  high while inside a frame (states HI, LO)
frame_done  output  1  single-cycle pulse: last pixel written
frame_error  output  1  single-cycle pulse: frame aborted by timeout

Behaviour:
- Reset (reset=0, async): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_error=0, hi-byte register=0, timeout counter=0. Reset mid-frame discards the partial frame; nothing is written afterwards until a new sync.
- All outputs registered.
- FSM states: IDLE, HI, LO.
  - IDLE: on rx_data_ready with rx_data==SYNC_BYTE (8'hA5) -> HI, pixel counter=0. Other bytes are ignored.
  - HI: on rx_data_ready, latch rx_data into hi register -> LO.
  - LO: on rx_data_ready, next cycle wr_en=1, wr_data={hi,rx_data}[PIXEL_WIDTH-1:0], wr_addr=current pixel index. Latency is exactly 1 clk from the low-byte strobe to wr_en. Pixel index then increments. If that index was H_RES*V_RES-1, frame_done=1 in the same cycle as wr_en, state -> IDLE and the index returns to 0. Otherwise -> HI.
- Inside a frame, SYNC_BYTE is ordinary data. There is no escaping and no resync.
- wr_addr holds its last written value between strobes. It is meaningful only when wr_en=1.
- Timeout:
  - In HI/LO, the counter clears on every rx_data_ready and otherwise increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no strobe: frame_error=1 for one cycle, state -> IDLE, pixel index=0, no write.
  - In IDLE the counter is held at 0.
  - If a strobe coincides with the terminal count, the byte wins: it is processed and the counter clears.
- busy=1 exactly while the state is HI or LO (registered with the state).
- frame_done and frame_error are never high in the same cycle.
- rx_data_ready strobes arrive at least 2 clk apart. Behaviour with back-to-back strobes is unspecified.

Decomposition:
- Package uart_writer_pkg holds:
  - SYNC_BYTE (8'hA5)
  - the loader state enum (IDLE, HI, LO)
  - the default resolution and timeout constants, shared with the VGA side
- Sub-module byte_timeout_timer:
  - inputs: clk, reset, enable, clear
  - output: expired pulse
  - parameterised by TIMEOUT_CYCLES and TIMEOUT_WIDTH
- The FSM, pixel counter and output registers stay in uart_frame_loader.

Test Plan:
Bench parameters are H_RES=4, V_RES=2, TIMEOUT_CYCLES=100, with strobes spaced 10 clk apart.
1. Reset, then send A5 followed by 8 pairs (0x0F,0xFF), (0x01,0x23), ... -> 8 wr_en pulses, each 1 clk after its low-byte strobe. wr_addr runs 0..7; first wr_data=12'hFFF, second 12'h123. frame_done coincides with addr 7; busy drops the next cycle.
2. Send 0x00, 0x11, 0xA5, then pixel pairs -> the leading 0x00 and 0x11 cause no writes and busy stays 0. The frame starts after 0xA5 and addresses begin at 0.
3. Sync, 3 full pixels, then silence -> exactly 100 cycles after the last strobe frame_error pulses once and busy=0. A following complete frame writes addresses 0..7 cleanly.
4. Inside a frame, send pixel (0xA5,0xA5) -> written as 12'h5A5 at the expected address; no resync occurs.
5. Assert reset mid-LO, release, then send a full frame -> no write from the partial frame. The new frame starts at addr 0 and wr_data reflects only the new bytes.
6. Deliver a byte strobe exactly at timeout terminal count -> no frame_error; the byte is accepted and the frame completes normally with frame_done.
